// File: rtl/load_store_unit_if.sv
// LSU command + data-bus signal bundle.
//   slave  : the load-store unit (responds to commands, drives the data bus)
//   master : memory access stage and bus fabric (issue commands, answer the bus)
// Command side: lsu_addr/lsu_wdata/lsu_cmd/lsu_rnw in; lsu_rdata/lsu_busy/
//   lsu_err_align/lsu_err_bus out.
// Bus side: bus_req/bus_addr/bus_rnw/bus_be/bus_wdata out; bus_ack/bus_err/
//   bus_rdata in.
interface load_store_unit_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [1:0]        lsu_cmd;
    logic              lsu_rnw;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_busy;
    logic              lsu_err_align;
    logic              lsu_err_bus;

    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rnw;
    logic [3:0]        bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic              bus_err;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  lsu_addr, lsu_wdata, lsu_cmd, lsu_rnw,
        output lsu_rdata, lsu_busy, lsu_err_align, lsu_err_bus,
        output bus_req, bus_addr, bus_rnw, bus_be, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport master (
        output lsu_addr, lsu_wdata, lsu_cmd, lsu_rnw,
        input  lsu_rdata, lsu_busy, lsu_err_align, lsu_err_bus,
        input  bus_req, bus_addr, bus_rnw, bus_be, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load-store unit: accepts one-cycle byte/halfword/word commands, checks
// alignment, runs one req/ack data-bus transaction with lane steering and
// byte enables, and returns right-justified zero-extended load data.
// Ports: clk, nrst (async active-low), lsu (slave side of load_store_unit_if).
// BUS_TIMEOUT: cycles in BUS before a missing ack becomes a bus error; 0 = off.
module load_store_unit #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input logic              clk,
    input logic              nrst,
    load_store_unit_if.slave lsu
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TO_W   = CNT_W + 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BUS_TIMEOUT);
    localparam bit TO_EN = (BUS_TIMEOUT != 0);

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_BYTE  = 2'd1;
    localparam logic [1:0] CMD_HWORD = 2'd2;
    localparam logic [1:0] CMD_WORD  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_ERR} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rnw_q, rnw_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_align_q, err_align_d;
    logic              err_bus_q, err_bus_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lo_q, lo_d;

    logic              misaligned;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] load_c;
    logic [TO_W-1:0]   cnt_inc;

    // Alignment, byte enables and lane replication for the incoming command
    always_comb begin
        misaligned = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = lsu.lsu_wdata;
        case (lsu.lsu_cmd)
            CMD_BYTE: begin
                be_c    = 4'b0001 << lsu.lsu_addr[1:0];
                wdata_c = {4{lsu.lsu_wdata[7:0]}};
            end
            CMD_HWORD: begin
                misaligned = lsu.lsu_addr[0];
                be_c       = lsu.lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{lsu.lsu_wdata[15:0]}};
            end
            CMD_WORD: begin
                misaligned = |lsu.lsu_addr[1:0];
                be_c       = 4'b1111;
            end
            default: ;
        endcase
    end

    // Lane extraction: aligned accesses make the byte offset a valid shift
    // for every size, so one shifter serves byte, halfword and word.
    always_comb begin
        rd_sh = lsu.bus_rdata >> {lo_q, 3'b000};
        case (size_q)
            CMD_BYTE:  load_c = DATA_W'(rd_sh[7:0]);
            CMD_HWORD: load_c = DATA_W'(rd_sh[15:0]);
            default:   load_c = rd_sh;
        endcase
    end

    assign cnt_inc = TO_W'(cnt_q) + TO_W'(1);

    // Next-state and next register values
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_align_d = 1'b0;
        err_bus_d   = 1'b0;
        cnt_d       = cnt_q;
        size_d      = size_q;
        lo_d        = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (lsu.lsu_cmd != CMD_IDLE) begin
                    if (misaligned) begin
                        state_d     = ST_ERR;
                        err_align_d = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        req_d   = 1'b1;
                        addr_d  = {lsu.lsu_addr[ADDR_W-1:2], 2'b00};
                        rnw_d   = lsu.lsu_rnw;
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        size_d  = lsu.lsu_cmd;
                        lo_d    = lsu.lsu_addr[1:0];
                        cnt_d   = '0;
                    end
                end
            end
            ST_BUS: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (lsu.bus_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    if (lsu.bus_err) begin
                        err_bus_d = 1'b1;
                    end else if (rnw_q) begin
                        rdata_d = load_c;
                    end
                end else if (TO_EN && (cnt_inc == TO_LIMIT)) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    err_bus_d = 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            rnw_q       <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_align_q <= 1'b0;
            err_bus_q   <= 1'b0;
            cnt_q       <= '0;
            size_q      <= CMD_IDLE;
            lo_q        <= 2'b00;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_align_q <= err_align_d;
            err_bus_q   <= err_bus_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            lo_q        <= lo_d;
        end
    end

    assign lsu.bus_req       = req_q;
    assign lsu.bus_addr      = addr_q;
    assign lsu.bus_rnw       = rnw_q;
    assign lsu.bus_be        = be_q;
    assign lsu.bus_wdata     = wdata_q;
    assign lsu.lsu_rdata     = rdata_q;
    assign lsu.lsu_err_align = err_align_q;
    assign lsu.lsu_err_bus   = err_bus_q;

    // Busy covers the command cycle itself so the core stalls immediately
    assign lsu.lsu_busy = ((state_q == ST_IDLE) && (lsu.lsu_cmd != CMD_IDLE)) ||
                          (state_q == ST_BUS);
endmodule
